muladd_dot_acc: RTL and testbench
=================================

MULADD_DOT_ACC -- requirements
Module: muladd_dot_acc

Interface
REQ-001 The block SHALL have parameter DW, default 16: signed operand and result width.
REQ-002 The block SHALL have parameter LANES, default 2: operand pairs multiplied per beat.
REQ-003 The block SHALL have parameter LEN_MAX, default 256: maximum beats per dot product.
REQ-004 The block SHALL have parameter SHIFT, default 8: arithmetic right shift applied to the accumulator before output.
REQ-005 The block SHALL have parameter ACCW, default 2*DW+$clog2(LANES*LEN_MAX)+1: accumulator width.
REQ-006 The block SHALL have these ports:
- clk_pe  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_len_i  in  16  beats per dot product; sampled on the first accepted beat.
- cfg_relu_i  in  1  ReLU enable; sampled on the first accepted beat.
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  input beat ready.
- in_a_i  in  LANES*DW  packed signed operands; lane 0 in the LSBs.
- in_b_i  in  LANES*DW  packed signed operands; lane 0 in the LSBs.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  result accepted.
- out_data_o  out  DW  signed result.
- out_ovf_o  out  1  saturation flag qualified by out_valid_o.
- busy_o  out  1  high in ACC and OUT.

Function
REQ-007 The block SHALL implement FSM states IDLE, ACC and OUT; a beat is accepted when in_valid_i and in_ready_o are both high at a clk_pe edge.
REQ-008 IDLE: on an accepted beat, the block SHALL latch len = (cfg_len_i==0 ? 1 : min(cfg_len_i, LEN_MAX)) and relu, load acc with the beat sum, and set cnt=1.
- Next state is OUT if len==1, else ACC.
REQ-009 ACC: each accepted beat SHALL add the beat sum to acc and increment cnt; the beat with cnt+1==len SHALL transition to OUT.
- Cycles without a beat hold all state.
REQ-010 Beat sum SHALL be the sum over all lanes of signed(a_l)*signed(b_l), computed at full 2*DW precision and sign-extended to ACCW; acc SHALL never wrap within LEN_MAX beats.
REQ-011 OUT: out_valid_o=1; data and flag SHALL be held stable until out_ready_i=1, at which edge the state returns to IDLE.
REQ-012 Result SHALL be computed as follows:
- r = acc >>> SHIFT (floor).
- If relu and r<0 then r=0.
- If r > 2^(DW-1)-1 or r < -2^(DW-1), clamp to that bound and set out_ovf_o=1; else out_ovf_o=0.
REQ-013 out_valid_o SHALL rise in the cycle after the last beat is accepted (latency 1), with out_data_o and out_ovf_o valid in that same cycle.
REQ-014 in_ready_o SHALL be registered: 1 in IDLE and ACC, 0 in OUT.
- It falls in the same cycle out_valid_o rises.
- It rises in the cycle after the output handshake.
- IDLE is not re-entered early and beats are not accepted during OUT.
REQ-015 cfg_len_i and cfg_relu_i changes after the first beat SHALL have no effect until the next IDLE acceptance.
REQ-016 busy_o SHALL equal (state != IDLE).

Reset
REQ-017 While rst=1, the block SHALL force state=IDLE, acc=0, cnt=0, in_ready_o=0, out_valid_o=0, out_data_o=0, out_ovf_o=0 and busy_o=0.
REQ-018 in_ready_o SHALL rise at the first clk_pe edge after rst deasserts.
REQ-019 Reset asserted mid-ACC or mid-OUT SHALL discard the partial or pending result, with no output beat emitted.

Verification (DW=16, LANES=2, SHIFT=8)
REQ-020 Unit dot product: len=1, a={0x0200,0x0100}, b={0x0100,0x0100} -> one cycle later out_valid_o=1, out_data_o=0x0300, out_ovf_o=0.
REQ-021 Saturation: len=4, every beat a=b={0x7FFF,0x7FFF} -> out_data_o=0x7FFF, out_ovf_o=1.
- Likewise a={0x8000,0x8000} with b={0x7FFF,0x7FFF} -> 0x8000, out_ovf_o=1.
REQ-022 ReLU: len=1, a={0x0000,0xFF00}, b={0x0000,0x0100}:
- relu=0 -> out_data_o=0xFF00.
- relu=1 -> out_data_o=0x0000, out_ovf_o=0.
REQ-023 Backpressure and stalls: len=3 with in_valid_i gaps, then out_ready_i low for 5 cycles -> out_data_o held constant, in_ready_o=0, and beats offered during OUT are not consumed; the next dot product is unaffected.
REQ-024 cfg_len_i=0 -> treated as 1; cfg_len_i changed after the first beat of len=4 -> exactly 4 beats consumed.
REQ-025 Reset mid-operation: rst pulse after 2 of 4 beats -> no out_valid_o, in_ready_o=0 during rst; a fresh len=1 transaction then yields the value from REQ-020.

Source files
------------

// File: rtl/muladd_dot_acc.sv
`default_nettype none
// ============================================================================
// Module   : muladd_dot_acc
// Purpose  : Streaming multi-lane signed dot product accumulator with
//            arithmetic shift, optional ReLU and saturating output.
// Revision : 1.0 - initial release
// ============================================================================
module muladd_dot_acc #(
    parameter int DW      = 16,
    parameter int LANES   = 2,
    parameter int LEN_MAX = 256,
    parameter int SHIFT   = 8,
    parameter int ACCW    = 2*DW + $clog2(LANES*LEN_MAX) + 1
) (
    input  logic                  clk_pe,
    input  logic                  rst,
    input  logic [15:0]           cfg_len_i,
    input  logic                  cfg_relu_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [LANES*DW-1:0]   in_a_i,
    input  logic [LANES*DW-1:0]   in_b_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DW-1:0]         out_data_o,
    output logic                  out_ovf_o,
    output logic                  busy_o
);

    localparam int CNTW = $clog2(LEN_MAX + 1);
    localparam logic signed [ACCW-1:0] c_sat_max = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] c_sat_min = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic signed [ACCW-1:0]  r_acc;
    logic signed [ACCW-1:0]  w_acc_nxt;
    logic [CNTW-1:0]         r_cnt;
    logic [CNTW-1:0]         w_cnt_nxt;
    logic [CNTW-1:0]         r_len;
    logic [CNTW-1:0]         w_len_nxt;
    logic [CNTW-1:0]         w_len_cfg;
    logic                    r_relu;
    logic                    w_relu_nxt;
    logic                    r_in_ready;
    logic [DW-1:0]           r_out_data;
    logic                    r_out_ovf;
    logic                    w_load_out;
    logic                    w_accept;
    logic signed [ACCW-1:0]  w_beat_sum;
    logic [DW:0]             w_result;

    // Returns {ovf, data}: floor shift, optional ReLU, then clamp to DW bits.
    function automatic logic [DW:0] f_result(input logic signed [ACCW-1:0] acc,
                                             input logic                   relu);
        logic signed [ACCW-1:0] v;
        v = acc >>> SHIFT;
        if (relu && v[ACCW-1]) begin
            v = '0;
        end
        if (v > c_sat_max) begin
            f_result = {1'b1, c_sat_max[DW-1:0]};
        end else if (v < c_sat_min) begin
            f_result = {1'b1, c_sat_min[DW-1:0]};
        end else begin
            f_result = {1'b0, v[DW-1:0]};
        end
    endfunction

    assign w_accept = in_valid_i && r_in_ready;

    always_comb begin : p_beat_sum
        logic signed [DW-1:0]   v_a;
        logic signed [2*DW-1:0] v_prod;
        logic signed [DW-1:0]   v_b;
        w_beat_sum = '0;
        v_a        = '0;
        v_b        = '0;
        v_prod     = '0;
        for (int l = 0; l < LANES; l++) begin
            v_a        = in_a_i[l*DW +: DW];
            v_b        = in_b_i[l*DW +: DW];
            v_prod     = (2*DW)'(v_a) * (2*DW)'(v_b);
            w_beat_sum = w_beat_sum + ACCW'(v_prod);
        end
    end

    // A zero length still produces one beat; oversize lengths clamp to LEN_MAX.
    always_comb begin
        if (cfg_len_i == '0) begin
            w_len_cfg = CNTW'(1);
        end else if (32'(cfg_len_i) > LEN_MAX) begin
            w_len_cfg = CNTW'(LEN_MAX);
        end else begin
            w_len_cfg = CNTW'(cfg_len_i);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_len_nxt   = r_len;
        w_relu_nxt  = r_relu;
        w_load_out  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_len_nxt  = w_len_cfg;
                    w_relu_nxt = cfg_relu_i;
                    w_acc_nxt  = w_beat_sum;
                    w_cnt_nxt  = CNTW'(1);
                    if (w_len_cfg == CNTW'(1)) begin
                        w_state_nxt = S_OUT;
                        w_load_out  = 1'b1;
                    end else begin
                        w_state_nxt = S_ACC;
                    end
                end
            end
            S_ACC: begin
                if (w_accept) begin
                    w_acc_nxt = r_acc + w_beat_sum;
                    w_cnt_nxt = r_cnt + CNTW'(1);
                    if (r_cnt + CNTW'(1) == r_len) begin
                        w_state_nxt = S_OUT;
                        w_load_out  = 1'b1;
                    end
                end
            end
            S_OUT: begin
                if (out_ready_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Result is formed from the final accumulator value so it is ready with out_valid_o.
    assign w_result = f_result(w_acc_nxt, w_relu_nxt);

    always_ff @(posedge clk_pe or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_len      <= '0;
            r_relu     <= 1'b0;
            r_in_ready <= 1'b0;
            r_out_data <= '0;
            r_out_ovf  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_acc      <= w_acc_nxt;
            r_cnt      <= w_cnt_nxt;
            r_len      <= w_len_nxt;
            r_relu     <= w_relu_nxt;
            r_in_ready <= (w_state_nxt != S_OUT);
            if (w_load_out) begin
                {r_out_ovf, r_out_data} <= w_result;
            end
        end
    end

    assign in_ready_o  = r_in_ready;
    assign out_valid_o = (r_state == S_OUT);
    assign out_data_o  = r_out_data;
    assign out_ovf_o   = r_out_ovf;
    assign busy_o      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_muladd_dot_acc.sv
`default_nettype none
// ============================================================================
// Module   : tb_muladd_dot_acc
// Purpose  : Self-checking bench for muladd_dot_acc against a plain-arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muladd_dot_acc;

    logic        clk_pe = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cfg_len_i = '0;
    logic        cfg_relu_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [31:0] in_a_i = '0;
    logic [31:0] in_b_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [15:0] out_data_o;
    logic        out_ovf_o;
    logic        busy_o;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] q_a[$];
    logic [31:0] q_b[$];

    always #5 clk_pe = ~clk_pe;

    muladd_dot_acc #(.DW(16), .LANES(2), .LEN_MAX(256), .SHIFT(8)) dut (
        .clk_pe      (clk_pe),
        .rst         (rst),
        .cfg_len_i   (cfg_len_i),
        .cfg_relu_i  (cfg_relu_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_a_i      (in_a_i),
        .in_b_i      (in_b_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_ovf_o   (out_ovf_o),
        .busy_o      (busy_o)
    );

    initial begin
        #3000000;
        $display("FAIL watchdog simulation did not finish, required finish");
        $fatal(1);
    end

    // Dot product of the queued beats as an ordinary integer.
    function automatic longint calc_acc();
        longint  acc = 0;
        shortint sa, sb;
        for (int i = 0; i < q_a.size(); i++) begin
            for (int l = 0; l < 2; l++) begin
                sa  = q_a[i][l*16 +: 16];
                sb  = q_b[i][l*16 +: 16];
                acc = acc + longint'(sa) * longint'(sb);
            end
        end
        return acc;
    endfunction

    function automatic void model(input longint acc, input bit relu,
                                  output logic [15:0] d, output bit ovf);
        longint r;
        r = acc / 256;
        if ((acc % 256 != 0) && (acc < 0)) r = r - 1;
        if (relu && r < 0) r = 0;
        ovf = 1'b0;
        if (r > 32767) begin
            d = 16'h7FFF; ovf = 1'b1;
        end else if (r < -32768) begin
            d = 16'h8000; ovf = 1'b1;
        end else begin
            d = r[15:0];
        end
    endfunction

    // Offers one beat at a negedge and returns at the negedge after acceptance.
    task automatic drive_beat(input logic [31:0] a, input logic [31:0] b);
        int k = 0;
        in_valid_i = 1'b1;
        in_a_i     = a;
        in_b_i     = b;
        while (!in_ready_o && k < 100) begin
            @(negedge clk_pe);
            k++;
        end
        if (!in_ready_o) begin
            n_total++;
            $display("FAIL beat_ready_timeout in_ready=%b required 1", in_ready_o);
        end
        @(negedge clk_pe);
        in_valid_i = 1'b0;
    endtask

    task automatic do_txn(input logic [15:0] cfg_len, input bit relu, input bit gaps,
                          input int stall, output bit got_valid, output logic [15:0] got_data,
                          output bit got_ovf, output bit got_busy, output bit hold_ok);
        hold_ok = 1'b1;
        for (int i = 0; i < q_a.size(); i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk_pe);
            if (i == 0) begin
                cfg_len_i  = cfg_len;
                cfg_relu_i = relu;
            end
            drive_beat(q_a[i], q_b[i]);
            cfg_len_i  = 16'($urandom);
            cfg_relu_i = 1'($urandom);
        end
        got_valid = out_valid_o;
        got_data  = out_data_o;
        got_ovf   = out_ovf_o;
        got_busy  = busy_o;
        for (int s = 0; s < stall; s++) begin
            in_valid_i = 1'b1;
            in_a_i     = $urandom;
            in_b_i     = $urandom;
            @(negedge clk_pe);
            if (out_valid_o !== 1'b1 || out_data_o !== got_data ||
                out_ovf_o !== got_ovf || in_ready_o !== 1'b0) hold_ok = 1'b0;
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        @(negedge clk_pe);
        out_ready_i = 1'b0;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || busy_o !== 1'b0) hold_ok = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk_pe);
        n_total++; if (in_ready_o !== 1'b0) $display("FAIL rst_in_ready got=%b exp=0", in_ready_o); else n_pass++;
        n_total++; if (out_valid_o !== 1'b0) $display("FAIL rst_out_valid got=%b exp=0", out_valid_o); else n_pass++;
        n_total++; if (out_data_o !== 16'h0) $display("FAIL rst_out_data got=%h exp=0000", out_data_o); else n_pass++;
        n_total++; if (out_ovf_o !== 1'b0) $display("FAIL rst_out_ovf got=%b exp=0", out_ovf_o); else n_pass++;
        n_total++; if (busy_o !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy_o); else n_pass++;
        rst = 1'b0;
        @(negedge clk_pe);
        n_total++; if (in_ready_o !== 1'b1) $display("FAIL rst_release_ready got=%b exp=1", in_ready_o); else n_pass++;
    endtask

    task automatic test_unit();
        bit v, o, b, h;
        logic [15:0] d;
        q_a = {32'h0200_0100}; q_b = {32'h0100_0100};
        do_txn(16'd1, 1'b0, 1'b0, 0, v, d, o, b, h);
        n_total++; if (v !== 1'b1) $display("FAIL unit_valid got=%b exp=1", v); else n_pass++;
        n_total++; if (d !== 16'h0300) $display("FAIL unit_data got=%h exp=0300", d); else n_pass++;
        n_total++; if (o !== 1'b0) $display("FAIL unit_ovf got=%b exp=0", o); else n_pass++;
        n_total++; if (b !== 1'b1) $display("FAIL unit_busy got=%b exp=1", b); else n_pass++;
        n_total++; if (h !== 1'b1) $display("FAIL unit_handshake got=%b exp=1", h); else n_pass++;
    endtask

    task automatic test_saturation();
        bit v, o, b, h;
        logic [15:0] d;
        q_a = {}; q_b = {};
        repeat (4) begin q_a.push_back(32'h7FFF_7FFF); q_b.push_back(32'h7FFF_7FFF); end
        do_txn(16'd4, 1'b0, 1'b0, 0, v, d, o, b, h);
        n_total++; if (v !== 1'b1 || d !== 16'h7FFF || o !== 1'b1)
            $display("FAIL sat_pos got v=%b d=%h o=%b exp v=1 d=7fff o=1", v, d, o); else n_pass++;
        q_a = {}; q_b = {};
        repeat (4) begin q_a.push_back(32'h8000_8000); q_b.push_back(32'h7FFF_7FFF); end
        do_txn(16'd4, 1'b0, 1'b0, 0, v, d, o, b, h);
        n_total++; if (v !== 1'b1 || d !== 16'h8000 || o !== 1'b1)
            $display("FAIL sat_neg got v=%b d=%h o=%b exp v=1 d=8000 o=1", v, d, o); else n_pass++;
    endtask

    task automatic test_relu();
        bit v, o, b, h;
        logic [15:0] d;
        q_a = {32'h0000_FF00}; q_b = {32'h0000_0100};
        do_txn(16'd1, 1'b0, 1'b0, 0, v, d, o, b, h);
        n_total++; if (d !== 16'hFF00 || o !== 1'b0)
            $display("FAIL relu_off got d=%h o=%b exp d=ff00 o=0", d, o); else n_pass++;
        do_txn(16'd1, 1'b1, 1'b0, 0, v, d, o, b, h);
        n_total++; if (d !== 16'h0000 || o !== 1'b0)
            $display("FAIL relu_on got d=%h o=%b exp d=0000 o=0", d, o); else n_pass++;
    endtask

    task automatic test_backpressure();
        bit v, o, b, h, eo;
        logic [15:0] d, ed;
        q_a = {32'h0010_FFF0, 32'h0123_0456, 32'hFF00_0100};
        q_b = {32'h0200_0300, 32'h0010_0020, 32'h0040_FFC0};
        model(calc_acc(), 1'b0, ed, eo);
        do_txn(16'd3, 1'b0, 1'b1, 5, v, d, o, b, h);
        n_total++; if (v !== 1'b1 || d !== ed || o !== eo)
            $display("FAIL bp_result got v=%b d=%h o=%b exp v=1 d=%h o=%b", v, d, o, ed, eo); else n_pass++;
        n_total++; if (h !== 1'b1) $display("FAIL bp_hold got=%b exp=1", h); else n_pass++;
        q_a = {32'h0100_0100, 32'h0200_0200}; q_b = {32'h0100_0100, 32'h0100_0100};
        model(calc_acc(), 1'b0, ed, eo);
        do_txn(16'd2, 1'b0, 1'b0, 0, v, d, o, b, h);
        n_total++; if (v !== 1'b1 || d !== ed || o !== eo)
            $display("FAIL bp_next got v=%b d=%h o=%b exp v=1 d=%h o=%b", v, d, o, ed, eo); else n_pass++;
    endtask

    task automatic test_len_cfg();
        bit v, o, b, h, eo;
        logic [15:0] d, ed;
        q_a = {32'h0003_0002}; q_b = {32'h0100_0100};
        model(calc_acc(), 1'b0, ed, eo);
        do_txn(16'd0, 1'b0, 1'b0, 0, v, d, o, b, h);
        n_total++; if (v !== 1'b1 || d !== ed) $display("FAIL len_zero got v=%b d=%h exp v=1 d=%h", v, d, ed); else n_pass++;
        q_a = {}; q_b = {};
        for (int i = 0; i < 4; i++) begin q_a.push_back(32'h0001_0001 * (i + 1)); q_b.push_back(32'h0100_0080); end
        model(calc_acc(), 1'b0, ed, eo);
        do_txn(16'd4, 1'b0, 1'b0, 0, v, d, o, b, h);
        n_total++; if (v !== 1'b1 || d !== ed) $display("FAIL len_four got v=%b d=%h exp v=1 d=%h", v, d, ed); else n_pass++;
        n_total++; if (h !== 1'b1) $display("FAIL len_four_handshake got=%b exp=1", h); else n_pass++;
        q_a = {}; q_b = {};
        for (int i = 0; i < 256; i++) begin q_a.push_back(32'h0010_FFF8); q_b.push_back(32'h0020_0010); end
        model(calc_acc(), 1'b0, ed, eo);
        do_txn(16'd300, 1'b0, 1'b0, 0, v, d, o, b, h);
        n_total++; if (v !== 1'b1 || d !== ed || o !== eo)
            $display("FAIL len_clamp got v=%b d=%h o=%b exp v=1 d=%h o=%b", v, d, o, ed, eo); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit v, o, b, h, saw_valid;
        logic [15:0] d;
        cfg_len_i = 16'd4; cfg_relu_i = 1'b0;
        drive_beat(32'h7FFF_7FFF, 32'h7FFF_7FFF);
        drive_beat(32'h7FFF_7FFF, 32'h7FFF_7FFF);
        rst = 1'b1;
        #1;
        saw_valid = out_valid_o;
        n_total++; if (in_ready_o !== 1'b0) $display("FAIL midrst_ready got=%b exp=0", in_ready_o); else n_pass++;
        n_total++; if (busy_o !== 1'b0) $display("FAIL midrst_busy got=%b exp=0", busy_o); else n_pass++;
        repeat (2) begin
            @(negedge clk_pe);
            saw_valid = saw_valid | out_valid_o;
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk_pe);
            saw_valid = saw_valid | out_valid_o;
        end
        n_total++; if (saw_valid !== 1'b0) $display("FAIL midrst_no_output got=%b exp=0", saw_valid); else n_pass++;
        q_a = {32'h0200_0100}; q_b = {32'h0100_0100};
        do_txn(16'd1, 1'b0, 1'b0, 0, v, d, o, b, h);
        n_total++; if (v !== 1'b1 || d !== 16'h0300 || o !== 1'b0)
            $display("FAIL midrst_fresh got v=%b d=%h o=%b exp v=1 d=0300 o=0", v, d, o); else n_pass++;
    endtask

    task automatic test_random();
        bit v, o, b, h, eo, relu;
        logic [15:0] d, ed, len;
        logic [15:0] x;
        int nb;
        logic [31:0] w;
        for (int t = 0; t < 25; t++) begin
            q_a = {}; q_b = {};
            nb   = $urandom_range(1, 6);
            relu = 1'($urandom);
            len  = (nb == 1 && $urandom_range(0, 1) == 1) ? 16'd0 : 16'(nb);
            for (int i = 0; i < nb; i++) begin
                for (int k = 0; k < 2; k++) begin
                    w = $urandom;
                    for (int l = 0; l < 2; l++) begin
                        x = w[l*16 +: 16];
                        if ($urandom_range(0, 3) != 0) x = {{6{x[9]}}, x[9:0]};
                        w[l*16 +: 16] = x;
                    end
                    if (k == 0) q_a.push_back(w); else q_b.push_back(w);
                end
            end
            model(calc_acc(), relu, ed, eo);
            do_txn(len, relu, 1'b1, $urandom_range(0, 3), v, d, o, b, h);
            n_total++; if (v !== 1'b1 || d !== ed || o !== eo || h !== 1'b1)
                $display("FAIL rand_%0d got v=%b d=%h o=%b hold=%b exp v=1 d=%h o=%b hold=1",
                         t, v, d, o, h, ed, eo);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_unit();
        test_saturation();
        test_relu();
        test_backpressure();
        test_len_cfg();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
